maze_solver: RTL and testbench

MAZE_SOLVER -- requirements
Module: maze_solver

---
 rtl/maze_pkg.sv | 26 ++
 rtl/maze_if.sv | 29 ++
 rtl/dir_stack.sv | 37 +++
 rtl/maze_solver.sv | 175 +++++++++++++++++
 tb/tb_maze_solver.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared types and constants for the maze solver
package maze_pkg;

  localparam int         MAZE_DIM  = 16;
  localparam logic [3:0] COORD_MAX = 4'(MAZE_DIM - 1);
  localparam logic [3:0] START_X   = 4'd0;
  localparam logic [3:0] START_Y   = 4'd0;
  localparam logic [3:0] GOAL_X    = COORD_MAX;
  localparam logic [3:0] GOAL_Y    = COORD_MAX;

  typedef enum logic [2:0] {
    S_IDLE, S_CHK_START, S_MARK, S_PROBE, S_MOVE, S_BACKTRACK, S_EMIT, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    DIR_XP = 2'd0,
    DIR_YP = 2'd1,
    DIR_XM = 2'd2,
    DIR_YM = 2'd3
  } dir_t;

  function automatic dir_t opposite(dir_t d);
    return dir_t'(d ^ 2'd2);
  endfunction

endpackage

// File: rtl/maze_if.sv
// rtl/maze_if.sv - solver control, maze-memory and path-stream signal bundle
interface maze_if;
  logic       start;
  logic [3:0] mem_x;
  logic [3:0] mem_y;
  logic       mem_rd;
  logic       mem_wr;
  logic       mem_wdata;
  logic       mem_rdata;
  logic       busy;
  logic       done;
  logic       found;
  logic [7:0] path_len;
  logic [1:0] dir;
  logic       dir_valid;
  logic       dir_ready;

  modport master (
    input  start, mem_rdata, dir_ready,
    output mem_x, mem_y, mem_rd, mem_wr, mem_wdata,
           busy, done, found, path_len, dir, dir_valid
  );

  modport slave (
    output start, mem_rdata, dir_ready,
    input  mem_x, mem_y, mem_rd, mem_wr, mem_wdata,
           busy, done, found, path_len, dir, dir_valid
  );
endinterface

// File: rtl/dir_stack.sv
// rtl/dir_stack.sv - 256x2 LIFO of moves, readable by index for path emission
module dir_stack (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [1:0] push_data_i,
  input  logic [7:0] rd_idx_i,
  output logic [1:0] rd_data_o,
  output logic [1:0] top_o,
  output logic [7:0] sp_o
);
  logic [1:0] mem_q [256];
  logic [7:0] sp_q, sp_d;

  always_comb begin
    sp_d = sp_q;
    if (clr_i)       sp_d = 8'd0;
    else if (push_i) sp_d = sp_q + 8'd1;
    else if (pop_i)  sp_d = sp_q - 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sp_q <= 8'd0;
    else     sp_q <= sp_d;
  end

  // Entry storage needs no reset; sp alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[sp_q] <= push_data_i;
  end

  assign rd_data_o = mem_q[rd_idx_i];
  assign top_o     = mem_q[sp_q - 8'd1];
  assign sp_o      = sp_q;
endmodule

// File: rtl/maze_solver.sv
// rtl/maze_solver.sv - depth-first maze solver that streams the found path as move codes
module maze_solver
  import maze_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  maze_if.master bus
);
  state_t     state_q, state_d;
  logic [3:0] cx_q, cx_d, cy_q, cy_d;
  logic [2:0] try_q, try_d;
  logic [7:0] eidx_q, eidx_d, plen_q, plen_d;
  logic       found_q, found_d;

  logic       stk_clr, stk_push, stk_pop;
  logic [1:0] stk_rd, stk_top;
  logic [7:0] sp;

  dir_t       step_dir;
  logic [3:0] nx, ny;
  logic       in_range;

  logic [3:0] mem_x, mem_y;
  logic       mem_rd, mem_wr, mem_wdata, dir_valid;
  logic [1:0] dir;

  dir_stack u_stack (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (stk_clr),
    .push_i     (stk_push),
    .pop_i      (stk_pop),
    .push_data_i(try_q[1:0]),
    .rd_idx_i   (eidx_q),
    .rd_data_o  (stk_rd),
    .top_o      (stk_top),
    .sp_o       (sp)
  );

  // One stepper serves both forward probing and retreating along the popped move.
  always_comb begin
    step_dir = (state_q == S_BACKTRACK) ? opposite(dir_t'(stk_top)) : dir_t'(try_q[1:0]);
    nx       = cx_q;
    ny       = cy_q;
    in_range = 1'b0;
    unique case (step_dir)
      DIR_XP: begin in_range = (cx_q != COORD_MAX); nx = cx_q + 4'd1; end
      DIR_YP: begin in_range = (cy_q != COORD_MAX); ny = cy_q + 4'd1; end
      DIR_XM: begin in_range = (cx_q != 4'd0);      nx = cx_q - 4'd1; end
      DIR_YM: begin in_range = (cy_q != 4'd0);      ny = cy_q - 4'd1; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    try_d     = try_q;
    eidx_d    = eidx_q;
    plen_d    = plen_q;
    found_d   = found_q;
    stk_clr   = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    mem_x     = 4'd0;
    mem_y     = 4'd0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = 1'b0;
    dir_valid = 1'b0;
    dir       = 2'd0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_CHK_START;
          cx_d    = START_X;
          cy_d    = START_Y;
          try_d   = 3'd0;
          eidx_d  = 8'd0;
          plen_d  = 8'd0;
          found_d = 1'b0;
          stk_clr = 1'b1;
        end
      end
      S_CHK_START: begin
        mem_rd  = 1'b1;
        mem_x   = START_X;
        mem_y   = START_Y;
        state_d = bus.mem_rdata ? S_DONE : S_MARK;
      end
      S_MARK: begin
        mem_wr    = 1'b1;
        mem_wdata = 1'b1;
        mem_x     = cx_q;
        mem_y     = cy_q;
        if (cx_q == GOAL_X && cy_q == GOAL_Y) begin
          found_d = 1'b1;
          plen_d  = sp;
          eidx_d  = 8'd0;
          state_d = S_EMIT;
        end else begin
          try_d   = 3'd0;
          state_d = S_PROBE;
        end
      end
      S_PROBE: begin
        if (try_q[2]) begin
          state_d = (sp == 8'd0) ? S_DONE : S_BACKTRACK;
        end else if (!in_range) begin
          try_d = try_q + 3'd1;
        end else begin
          mem_rd = 1'b1;
          mem_x  = nx;
          mem_y  = ny;
          if (!bus.mem_rdata) begin
            stk_push = 1'b1;
            cx_d     = nx;
            cy_d     = ny;
            state_d  = S_MARK;
          end else begin
            try_d = try_q + 3'd1;
          end
        end
      end
      S_BACKTRACK: begin
        stk_pop = 1'b1;
        cx_d    = nx;
        cy_d    = ny;
        try_d   = {1'b0, stk_top} + 3'd1;
        state_d = S_PROBE;
      end
      S_EMIT: begin
        dir_valid = 1'b1;
        dir       = stk_rd;
        if (bus.dir_ready) begin
          eidx_d = eidx_q + 8'd1;
          if (eidx_q == sp - 8'd1) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cx_q    <= START_X;
      cy_q    <= START_Y;
      try_q   <= 3'd0;
      eidx_q  <= 8'd0;
      plen_q  <= 8'd0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      try_q   <= try_d;
      eidx_q  <= eidx_d;
      plen_q  <= plen_d;
      found_q <= found_d;
    end
  end

  assign bus.mem_x     = mem_x;
  assign bus.mem_y     = mem_y;
  assign bus.mem_rd    = mem_rd;
  assign bus.mem_wr    = mem_wr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.found     = found_q;
  assign bus.path_len  = plen_q;
  assign bus.dir       = dir;
  assign bus.dir_valid = dir_valid;
endmodule

// File: tb/tb_maze_solver.sv
// tb/tb_maze_solver.sv - directed table-driven bench for maze_solver
module tb_maze_solver;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  maze_if bus();
  maze_solver dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    int              maze_id;
    bit              stall;
    bit              exp_found;
    int              exp_len;
    bit              chk_nowr;
    bit              chk_fill;
    int              nruns;
    logic [2:0][1:0] rdir;
    logic [2:0][7:0] rcnt;
  } vec_t;

  vec_t vecs [5];
  logic maze [16][16];
  int   stream [$];
  int   n_vec, n_err, wr_count, overlap, stall_bad;

  assign bus.mem_rdata = bus.mem_rd ? maze[bus.mem_x][bus.mem_y] : 1'b0;

  always @(negedge clk) begin
    if (bus.mem_rd && bus.mem_wr) overlap++;
    if (bus.mem_wr) begin
      maze[bus.mem_x][bus.mem_y] = bus.mem_wdata;
      wr_count++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_maze(input int id);
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) maze[x][y] = 1'b0;
    case (id)
      1: maze[0][0] = 1'b1;
      2: begin maze[14][15] = 1'b1; maze[15][14] = 1'b1; end
      3: begin
        for (int x = 1; x < 16; x++) maze[x][1] = 1'b1;
        maze[15][0] = 1'b1;
      end
      default: ;
    endcase
  endtask

  task automatic set_vec(input int i, input int id, input bit stall, input bit f, input int len,
                         input bit nowr, input bit fill, input int nr,
                         input int d0, input int c0, input int d1, input int c1,
                         input int d2, input int c2);
    vecs[i].maze_id = id;   vecs[i].stall = stall; vecs[i].exp_found = f;
    vecs[i].exp_len = len;  vecs[i].chk_nowr = nowr; vecs[i].chk_fill = fill;
    vecs[i].nruns = nr;
    vecs[i].rdir[0] = 2'(d0); vecs[i].rcnt[0] = 8'(c0);
    vecs[i].rdir[1] = 2'(d1); vecs[i].rcnt[1] = 8'(c1);
    vecs[i].rdir[2] = 2'(d2); vecs[i].rcnt[2] = 8'(c2);
  endtask

  // Pulses start and collects every accepted dir until done; optionally stalls mid-stream.
  task automatic run_solve(input bit stall);
    int   cyc;
    bit   stalled;
    logic [1:0] hold;
    stream.delete();
    stalled   = 1'b0;
    stall_bad = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 20000) begin
      if (stall && !stalled && bus.dir_valid && stream.size() == 12) begin
        bus.dir_ready = 1'b0;
        hold = bus.dir;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          cyc++;
          if (bus.dir !== hold || bus.dir_valid !== 1'b1) stall_bad++;
        end
        bus.dir_ready = 1'b1;
        stalled = 1'b1;
      end
      if (bus.dir_valid && bus.dir_ready) stream.push_back(int'(bus.dir));
      @(negedge clk);
      cyc++;
    end
    check("solve_finished", int'(cyc < 20000), 1);
  endtask

  task automatic check_result(input vec_t v);
    int exp_s [$];
    for (int r = 0; r < v.nruns; r++)
      for (int k = 0; k < int'(v.rcnt[r]); k++) exp_s.push_back(int'(v.rdir[r]));
    check("done", int'(bus.done), 1);
    check("busy", int'(bus.busy), 0);
    check("found", int'(bus.found), int'(v.exp_found));
    check("path_len", int'(bus.path_len), v.exp_len);
    check("stream_len", stream.size(), exp_s.size());
    for (int k = 0; k < exp_s.size(); k++)
      check($sformatf("dir[%0d]", k), (k < stream.size()) ? stream[k] : -1, exp_s[k]);
  endtask

  initial begin
    int cyc, unmarked;
    n_vec = 0; n_err = 0; wr_count = 0; overlap = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dir_ready = 1'b1;
    load_maze(0);
    repeat (3) @(negedge clk);
    check("rst_mem_rd", int'(bus.mem_rd), 0);
    check("rst_mem_wr", int'(bus.mem_wr), 0);
    check("rst_wdata", int'(bus.mem_wdata), 0);
    check("rst_mem_xy", int'({bus.mem_x, bus.mem_y}), 0);
    check("rst_status", int'({bus.busy, bus.done, bus.found}), 0);
    check("rst_path_len", int'(bus.path_len), 0);
    check("rst_dir", int'({bus.dir_valid, bus.dir}), 0);
    rst = 1'b0;
    @(negedge clk);

    set_vec(0, 0, 1'b0, 1'b1, 30, 1'b0, 1'b0, 2, 0, 15, 1, 15, 0, 0);
    set_vec(1, 1, 1'b0, 1'b0, 0,  1'b1, 1'b0, 0, 0, 0,  0, 0,  0, 0);
    set_vec(2, 2, 1'b0, 1'b0, 0,  1'b0, 1'b1, 0, 0, 0,  0, 0,  0, 0);
    set_vec(3, 3, 1'b0, 1'b1, 30, 1'b0, 1'b0, 3, 1, 2,  0, 15, 1, 13);
    set_vec(4, 0, 1'b1, 1'b1, 30, 1'b0, 1'b0, 2, 0, 15, 1, 15, 0, 0);

    for (int i = 0; i < 5; i++) begin
      load_maze(vecs[i].maze_id);
      wr_count = 0;
      run_solve(vecs[i].stall);
      check_result(vecs[i]);
      if (vecs[i].chk_nowr) check("no_mem_wr", wr_count, 0);
      if (vecs[i].stall) check("stall_hold", stall_bad, 0);
      if (vecs[i].chk_fill) begin
        unmarked = 0;
        for (int x = 0; x < 16; x++)
          for (int y = 0; y < 16; y++)
            if (!(x == 15 && y == 15) && maze[x][y] !== 1'b1) unmarked++;
        check("unmarked_cells", unmarked, 0);
      end
    end

    // Reset while probing, then a clean re-solve from the start cell.
    load_maze(0);
    wr_count = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (!(wr_count >= 5 && bus.mem_rd) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("probe_reached", int'(cyc < 1000), 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_mem_rd", int'(bus.mem_rd), 0);
    check("midrst_mem_wr", int'(bus.mem_wr), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_done_found", int'({bus.done, bus.found}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_maze(0);
    run_solve(1'b0);
    check_result(vecs[0]);

    check("rd_wr_overlap", overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
